// File: rtl/spi_fetch_pkg.sv
// Shared types and constants for the SPI instruction fetch buffer.
package spi_fetch_pkg;
  localparam int ADDR_W_DEFAULT = 24;
  localparam int INSTR_W        = 32;

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    IDLE      = 2'd1,
    FETCH     = 2'd2,
    PREFETCH  = 2'd3
  } state_t;
endpackage

// File: rtl/spi_fetch_store.sv
// Direct-mapped word store: ENTRIES x {valid, tag, data}, one combinational
// lookup port, one write port, and a flush that clears every valid bit.
module spi_fetch_store
  import spi_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int ENTRIES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic               o_rd_hit,
  output logic [INSTR_W-1:0] o_rd_data,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [INSTR_W-1:0] i_wr_data
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag  [ENTRIES];
  logic [INSTR_W-1:0] r_data [ENTRIES];
  logic [IDX_W-1:0]   w_rd_idx;
  logic [IDX_W-1:0]   w_wr_idx;

  assign w_rd_idx  = i_rd_addr[IDX_W-1:0];
  assign w_wr_idx  = i_wr_addr[IDX_W-1:0];
  assign o_rd_hit  = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == i_rd_addr[ADDR_W-1:IDX_W]);
  assign o_rd_data = r_data[w_rd_idx];

  // Flush has priority over a fill landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en && !i_flush) begin
      r_tag[w_wr_idx]  <= i_wr_addr[ADDR_W-1:IDX_W];
      r_data[w_wr_idx] <= i_wr_data;
    end
  end
endmodule

// File: rtl/spi_fetch_buffer.sv
// Instruction fetch buffer in front of the quad-SPI flash reader.
// Define SPI_FETCH_PREFETCH_EN to fetch addr+1 after every demand miss.
module spi_fetch_buffer
  import spi_fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int ENTRIES = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic               cpu_start,
  output logic [INSTR_W-1:0] cpu_q,
  output logic               cpu_done,
  output logic               cpu_busy,
  output logic               cpu_err,
  input  logic               flush,
  output logic [ADDR_W-1:0]  spi_address,
  output logic               spi_start,
  input  logic [INSTR_W-1:0] spi_instr,
  input  logic               spi_init_done,
  input  logic               spi_recv_done,
  output state_t             dbg_state
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  // Handshake: spi_start is a level held for the whole FETCH/PREFETCH stay and
  // drops on the edge that samples spi_recv_done; cpu_done is a one-cycle pulse.
  state_t             r_state, w_next;
  logic [ADDR_W-1:0]  r_spi_addr, r_pend_addr, w_rd_addr, w_launch_addr;
  logic [INSTR_W-1:0] r_q, w_ans_q, w_rd_data;
  logic [TMR_W-1:0]   r_timer;
  logic               r_done, r_err, r_pend, r_discard;
  logic               w_hit, w_fill, w_ans, w_ans_err, w_launch;
  logic               w_pend_set, w_pend_clr, w_active, w_timeout;

  spi_fetch_store #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES)) u_store (
    .clk       (clk),
    .rst_n     (reset),
    .i_flush   (flush),
    .i_rd_addr (w_rd_addr),
    .o_rd_hit  (w_hit),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_fill),
    .i_wr_addr (r_spi_addr),
    .i_wr_data (spi_instr)
  );

  assign w_active    = (r_state == FETCH) || (r_state == PREFETCH);
  assign w_timeout   = (r_timer == TMR_W'(TIMEOUT - 1));
  assign spi_start   = w_active;
  assign spi_address = r_spi_addr;
  assign cpu_q       = r_q;
  assign cpu_done    = r_done;
  assign cpu_err     = r_err;
  assign cpu_busy    = (r_state == WAIT_INIT) || (r_state == FETCH) || r_pend;
  assign dbg_state   = r_state;

  always_comb begin
    w_next        = r_state;
    w_rd_addr     = cpu_addr;
    w_fill        = 1'b0;
    w_ans         = 1'b0;
    w_ans_q       = '0;
    w_ans_err     = 1'b0;
    w_launch      = 1'b0;
    w_launch_addr = cpu_addr;
    w_pend_set    = 1'b0;
    w_pend_clr    = 1'b0;
    case (r_state)
      WAIT_INIT: if (spi_init_done) w_next = IDLE;
      IDLE: begin
        // A request parked during a prefetch is re-checked against the filled store.
        w_rd_addr = r_pend ? r_pend_addr : cpu_addr;
        if (!spi_init_done) begin
          w_next     = WAIT_INIT;
          w_pend_clr = 1'b1;
        end else if (r_pend || cpu_start) begin
          w_pend_clr = 1'b1;
          if (w_hit && !flush) begin
            w_ans   = 1'b1;
            w_ans_q = w_rd_data;
          end else begin
            w_next        = FETCH;
            w_launch      = 1'b1;
            w_launch_addr = w_rd_addr;
          end
        end
      end
      FETCH: begin
        w_rd_addr = r_spi_addr + 1'b1;
        if (!spi_init_done) begin
          w_next = WAIT_INIT;
        end else if (spi_recv_done) begin
          w_fill  = !r_discard && !flush;
          w_ans   = 1'b1;
          w_ans_q = spi_instr;
          w_next  = IDLE;
`ifdef SPI_FETCH_PREFETCH_EN
          if (!(w_hit && !flush)) begin
            w_next        = PREFETCH;
            w_launch      = 1'b1;
            w_launch_addr = w_rd_addr;
          end
`endif
        end else if (w_timeout) begin
          w_ans     = 1'b1;
          w_ans_err = 1'b1;
          w_next    = IDLE;
        end
      end
`ifdef SPI_FETCH_PREFETCH_EN
      PREFETCH: begin
        if (!spi_init_done) begin
          w_next     = WAIT_INIT;
          w_pend_clr = 1'b1;
        end else begin
          if (cpu_start && !r_pend) begin
            if (w_hit && !flush) begin
              w_ans   = 1'b1;
              w_ans_q = w_rd_data;
            end else begin
              w_pend_set = 1'b1;
            end
          end
          if (spi_recv_done) begin
            w_fill = !r_discard && !flush;
            w_next = IDLE;
          end else if (w_timeout) begin
            w_next = IDLE;
          end
        end
      end
`endif
      default: w_next = WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= WAIT_INIT;
      r_spi_addr  <= '0;
      r_pend_addr <= '0;
      r_q         <= '0;
      r_timer     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_pend      <= 1'b0;
      r_discard   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_ans;
      r_err   <= w_ans_err;
      if (w_ans) r_q <= w_ans_q;
      if (w_launch) r_spi_addr <= w_launch_addr;
      r_timer <= (w_active && !w_launch) ? r_timer + 1'b1 : '0;
      // A flush seen mid-transaction poisons that transaction's fill only.
      if (w_launch) r_discard <= 1'b0;
      else if (w_active && flush) r_discard <= 1'b1;
      if (w_pend_set) begin
        r_pend      <= 1'b1;
        r_pend_addr <= cpu_addr;
      end else if (w_pend_clr) begin
        r_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_fetch_buffer.sv
// Directed bench for spi_fetch_buffer with an expected-response queue.
module tb_spi_fetch_buffer;
  import spi_fetch_pkg::*;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_start = 1'b0;
  logic [31:0]   cpu_q;
  logic          cpu_done, cpu_busy, cpu_err;
  logic          flush = 1'b0;
  logic [AW-1:0] spi_address;
  logic          spi_start;
  logic [31:0]   spi_instr = '0;
  logic          spi_init_done = 1'b0;
  logic          spi_recv_done = 1'b0;
  state_t        dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_req    = 0;
  logic [32:0] exp_q[$];

  spi_fetch_buffer #(.ADDR_W(AW), .ENTRIES(4), .TIMEOUT(255)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_addr      (cpu_addr),
    .cpu_start     (cpu_start),
    .cpu_q         (cpu_q),
    .cpu_done      (cpu_done),
    .cpu_busy      (cpu_busy),
    .cpu_err       (cpu_err),
    .flush         (flush),
    .spi_address   (spi_address),
    .spi_start     (spi_start),
    .spi_instr     (spi_instr),
    .spi_init_done (spi_init_done),
    .spi_recv_done (spi_recv_done),
    .dbg_state     (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every cpu_done pops one expected {err, q}
  always @(negedge clk) begin
    if (reset && cpu_done) begin
      chk("done_has_expectation", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("done_err_q", {cpu_err, cpu_q}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [AW-1:0] a, input logic fl);
    int n = 0;
    while (cpu_busy && n < 300) begin
      step();
      n++;
    end
    chk("req_busy_low", cpu_busy, 0);
    cpu_addr  = a;
    cpu_start = 1'b1;
    flush     = fl;
    step();
    t_req     = cyc;
    cpu_start = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic pulse_recv(input logic [31:0] d);
    spi_instr     = d;
    spi_recv_done = 1'b1;
    step();
    spi_recv_done = 1'b0;
  endtask

  task automatic miss(input logic [AW-1:0] a, input logic [31:0] d, input int hold);
    req(a, 1'b0);
    chk("miss_spi_start", spi_start, 1);
    chk("miss_spi_address", spi_address, a);
    chk("miss_busy", cpu_busy, 1);
    repeat (hold) step();
    chk("miss_start_held", spi_start, 1);
    exp_q.push_back({1'b0, d});
    pulse_recv(d);
    chk("miss_done_after_recv", cpu_done, 1);
  endtask

  task automatic hit(input logic [AW-1:0] a, input logic [31:0] d);
    exp_q.push_back({1'b0, d});
    req(a, 1'b0);
    chk("hit_latency1_done", cpu_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset held with reader not initialised
    repeat (10) @(negedge clk);
    chk("rst_busy", cpu_busy, 1);
    chk("rst_spi_start", spi_start, 0);
    chk("rst_spi_address", spi_address, 0);
    chk("rst_done", cpu_done, 0);
    chk("rst_q", cpu_q, 0);
    chk("rst_state", dbg_state, WAIT_INIT);
    reset = 1'b1;
    repeat (3) step();
    chk("wait_init_busy", cpu_busy, 1);
    spi_init_done = 1'b1;
    step();
    chk("init_busy_low", cpu_busy, 0);
    chk("init_idle", dbg_state, IDLE);

`ifdef SPI_FETCH_PREFETCH_EN
    miss(24'hFFFFFF, 32'hA0A0A0A0, 2);
    chk("pf_start", spi_start, 1);
    chk("pf_addr_wrap", spi_address, 24'h000000);
    chk("pf_busy_low", cpu_busy, 0);
    pulse_recv(32'hB1B1B1B1);
    chk("pf_fill_silent", cpu_done, 0);
    chk("pf_back_idle", dbg_state, IDLE);
    hit(24'h000000, 32'hB1B1B1B1);
    miss(24'h000020, 32'hC2C2C2C2, 1);
    chk("pf2_addr", spi_address, 24'h000021);
    exp_q.push_back({1'b0, 32'hD3D3D3D3});
    req(24'h000021, 1'b0);
    chk("pf_pend_busy", cpu_busy, 1);
    chk("pf_pend_no_done", cpu_done, 0);
    repeat (3) step();
    pulse_recv(32'hD3D3D3D3);
    chk("pf_pend_fill_no_done", cpu_done, 0);
    step();
    chk("pf_pend_served", cpu_done, 1);
    chk("pf_pend_no_refetch", spi_start, 0);
    miss(24'h000032, 32'hE4E4E4E4, 0);
    chk("pf3_addr", spi_address, 24'h000033);
    hit(24'h000021, 32'hD3D3D3D3);
    chk("pf3_still_fetching", spi_start, 1);
    pulse_recv(32'hF5F5F5F5);
    chk("pf3_fill_silent", cpu_done, 0);
    hit(24'h000033, 32'hF5F5F5F5);
`else
    // cold miss then repeat hit
    miss(24'h000010, 32'hDEADBEEF, 4);
    chk("miss_start_drop", spi_start, 0);
    hit(24'h000010, 32'hDEADBEEF);
    chk("hit_no_spi", spi_start, 0);
    chk("hit_latency_cycles", cyc - t_req + 1, 1);
    // eviction on the shared index 0
    miss(24'h000014, 32'h11111111, 2);
    miss(24'h000010, 32'h22222222, 1);
    miss(24'h000011, 32'h33333333, 0);
    miss(24'h000012, 32'h44444444, 3);
    hit(24'h000011, 32'h33333333);
    hit(24'h000010, 32'h22222222);
    hit(24'h000012, 32'h44444444);
    // timeout: reader never answers
    req(24'h000033, 1'b0);
    exp_q.push_back({1'b1, 32'h0});
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cpu_done) break;
      if (spi_start) n++;
    end
    chk("timeout_done", cpu_done, 1);
    chk("timeout_err", cpu_err, 1);
    chk("timeout_start_cycles", n, 255);
    chk("timeout_start_low", spi_start, 0);
    miss(24'h000033, 32'h55555555, 0);
    // flush mid-fetch, with an ignored request while busy
    req(24'h000040, 1'b0);
    chk("flush_fetch_start", spi_start, 1);
    cpu_addr  = 24'h000011;
    cpu_start = 1'b1;
    flush     = 1'b1;
    step();
    cpu_start = 1'b0;
    flush     = 1'b0;
    chk("busy_req_ignored", spi_address, 24'h000040);
    exp_q.push_back({1'b0, 32'h66666666});
    pulse_recv(32'h66666666);
    chk("flush_demand_returned", cpu_done, 1);
    miss(24'h000040, 32'h77777777, 1);
    hit(24'h000040, 32'h77777777);
    // flush and start together: flush wins
    exp_q.push_back({1'b0, 32'h88888888});
    req(24'h000040, 1'b1);
    chk("flush_start_miss", spi_start, 1);
    chk("flush_start_no_done", cpu_done, 0);
    pulse_recv(32'h88888888);
    chk("flush_start_done", cpu_done, 1);
    // asynchronous reset during a fetch
    req(24'h000050, 1'b0);
    chk("rst2_fetching", spi_start, 1);
    #3 reset = 1'b0;
    #1;
    chk("rst2_async_start", spi_start, 0);
    chk("rst2_state", dbg_state, WAIT_INIT);
    chk("rst2_busy", cpu_busy, 1);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("rst2_idle", dbg_state, IDLE);
    miss(24'h000040, 32'h99999999, 0);
    // reader loses init: abort to WAIT_INIT, buffer contents kept
    spi_init_done = 1'b0;
    step();
    chk("init_drop_state", dbg_state, WAIT_INIT);
    chk("init_drop_busy", cpu_busy, 1);
    spi_init_done = 1'b1;
    step();
    chk("init_back_idle", dbg_state, IDLE);
    hit(24'h000040, 32'h99999999);
`endif

    repeat (3) step();
    chk("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
